// File: rtl/aes_io_pkg.sv
// Shared AES word/block I/O definitions used by the block serializer and the
// word-to-block loader.
package aes_io_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_NWORDS  = AES_BLOCK_W / AES_WORD_W;
  localparam int AES_IDX_W   = $clog2(AES_NWORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } aes_io_state_e;

  typedef logic [AES_IDX_W-1:0]   aes_word_idx_t;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;

  // Word idx counted from the end that is transmitted first.
  function automatic aes_word_t aes_word_sel(input aes_block_t    blk,
                                             input aes_word_idx_t idx,
                                             input logic          msw_first);
    aes_word_t w;
    if (msw_first) begin
      w = blk[AES_BLOCK_W-1 - int'(idx)*AES_WORD_W -: AES_WORD_W];
    end else begin
      w = blk[int'(idx)*AES_WORD_W +: AES_WORD_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_block_serializer_if.sv
// Block-in / word-out handshake bundle of the AES block serializer.
interface aes_block_serializer_if
  import aes_io_pkg::*;
#(
  parameter int WORD_W  = AES_WORD_W,
  parameter int BLOCK_W = AES_BLOCK_W
);
  localparam int IDX_W = $clog2(BLOCK_W / WORD_W);

  logic               blk_valid;
  logic               blk_ready;
  logic [BLOCK_W-1:0] blk_data;
  logic               wd_valid;
  logic               wd_ready;
  logic [WORD_W-1:0]  wd_data;
  logic [IDX_W-1:0]   wd_idx;
  logic               wd_last;
  logic               busy;

  modport slave (
    input  blk_valid, blk_data, wd_ready,
    output blk_ready, wd_valid, wd_data, wd_idx, wd_last, busy
  );

  modport master (
    output blk_valid, blk_data, wd_ready,
    input  blk_ready, wd_valid, wd_data, wd_idx, wd_last, busy
  );

endinterface

// File: rtl/aes_block_serializer.sv
// Splits one BLOCK_W block into NWORDS words, one per accepted output beat;
// the next block can be taken on the last-word beat with no idle cycle.
module aes_block_serializer
  import aes_io_pkg::*;
#(
  parameter int WORD_W    = AES_WORD_W,
  parameter int BLOCK_W   = AES_BLOCK_W,
  parameter bit MSW_FIRST = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  aes_block_serializer_if.slave bus
);

  localparam int               NWORDS   = BLOCK_W / WORD_W;
  localparam int               IDX_W    = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  aes_io_state_e      state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0] shift_q, shift_d;
  logic               wd_valid_q, wd_valid_d;
  logic               wd_last_q, wd_last_d;
  logic [WORD_W-1:0]  wd_data_q, wd_data_d;
  logic [WORD_W-1:0]  head_s;
  logic               out_xfer_s;
  logic               blk_ready_s;

  // Next state, shift register and index update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    blk_ready_s = 1'b0;
    out_xfer_s  = wd_valid_q && bus.wd_ready;
    case (state_q)
      IDLE: begin
        blk_ready_s = 1'b1;
        if (bus.blk_valid) begin
          shift_d = bus.blk_data;
          idx_d   = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        // Last beat frees the register, so the next block may load on the same edge.
        blk_ready_s = (idx_q == LAST_IDX) && bus.wd_ready;
        if (out_xfer_s && (idx_q == LAST_IDX)) begin
          if (bus.blk_valid) begin
            shift_d = bus.blk_data;
            idx_d   = '0;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else if (out_xfer_s) begin
          shift_d = MSW_FIRST ? (shift_q << WORD_W) : (shift_q >> WORD_W);
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Current word always sits at the transmit end of the shift register
  generate
    if ((BLOCK_W == AES_BLOCK_W) && (WORD_W == AES_WORD_W)) begin : g_pkg_sel
      assign head_s = aes_word_sel(shift_d, '0, MSW_FIRST);
    end else begin : g_gen_sel
      assign head_s = MSW_FIRST ? shift_d[BLOCK_W-1 -: WORD_W] : shift_d[WORD_W-1:0];
    end
  endgenerate

  assign wd_valid_d = (state_d == SEND);
  assign wd_last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
  assign wd_data_d  = (state_d == SEND) ? head_s : '0;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      wd_valid_q <= 1'b0;
      wd_last_q  <= 1'b0;
      wd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      wd_valid_q <= wd_valid_d;
      wd_last_q  <= wd_last_d;
      wd_data_q  <= wd_data_d;
    end
  end

  assign bus.blk_ready = blk_ready_s;
  assign bus.wd_valid  = wd_valid_q;
  assign bus.wd_data   = wd_data_q;
  assign bus.wd_idx    = idx_q;
  assign bus.wd_last   = wd_last_q;
  assign bus.busy      = (state_q == SEND);

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench for aes_block_serializer: MSW-first and LSW-first instances,
// back-to-back blocks, backpressure, mid-block reset and ignored input.
module tb_aes_block_serializer;
  import aes_io_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  localparam logic [127:0] BLK_X = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_A = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] BLK_B = 128'hF1F2F3F4_E5E6E7E8_D9DADBDC_CDCECFC0;
  localparam logic [127:0] BLK_C = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] BLK_D = 128'h55555555_AAAAAAAA_33333333_CCCCCCCC;

  logic [31:0] xw [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
  logic [6:0]  pat;
  int          cnt;

  aes_block_serializer_if #(.WORD_W(32), .BLOCK_W(128)) a_if ();
  aes_block_serializer_if #(.WORD_W(32), .BLOCK_W(128)) b_if ();

  aes_block_serializer #(.WORD_W(32), .BLOCK_W(128), .MSW_FIRST(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  aes_block_serializer #(.WORD_W(32), .BLOCK_W(128), .MSW_FIRST(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] msw_word(input logic [127:0] blk, input int i);
    logic [127:0] t;
    t = blk >> (32 * (3 - i));
    return t[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input bit use_b, input string tag, input logic [31:0] ed,
                          input int eix, input bit el);
    if (use_b) begin
      chk({tag, "_valid"}, 32'(b_if.wd_valid), 32'd1);
      chk({tag, "_data"},  b_if.wd_data, ed);
      chk({tag, "_idx"},   32'(b_if.wd_idx), eix);
      chk({tag, "_last"},  32'(b_if.wd_last), 32'(el));
      chk({tag, "_busy"},  32'(b_if.busy), 32'd1);
    end else begin
      chk({tag, "_valid"}, 32'(a_if.wd_valid), 32'd1);
      chk({tag, "_data"},  a_if.wd_data, ed);
      chk({tag, "_idx"},   32'(a_if.wd_idx), eix);
      chk({tag, "_last"},  32'(a_if.wd_last), 32'(el));
      chk({tag, "_busy"},  32'(a_if.busy), 32'd1);
    end
  endtask

  initial begin
    a_if.blk_valid = 1'b0; a_if.blk_data = '0; a_if.wd_ready = 1'b0;
    b_if.blk_valid = 1'b0; b_if.blk_data = '0; b_if.wd_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(a_if.wd_valid), 32'd0);
    chk("rst_data",  a_if.wd_data, 32'd0);
    chk("rst_idx",   32'(a_if.wd_idx), 32'd0);
    chk("rst_last",  32'(a_if.wd_last), 32'd0);
    chk("rst_busy",  32'(a_if.busy), 32'd0);
    chk("rst_b_valid", 32'(b_if.wd_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", 32'(a_if.blk_ready), 32'd1);

    // single block, MSW first
    @(negedge clk);
    a_if.blk_valid = 1'b1; a_if.blk_data = BLK_X; a_if.wd_ready = 1'b1;
    #1;
    chk("s1_rdy_idle", 32'(a_if.blk_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_if.blk_valid = 1'b0;
      #1;
      chk_word(1'b0, $sformatf("s1_w%0d", i), xw[i], i, (i == 3));
      chk($sformatf("s1_rdy%0d", i), 32'(a_if.blk_ready), 32'(i == 3));
    end
    @(negedge clk);
    #1;
    chk("s1_end_valid", 32'(a_if.wd_valid), 32'd0);
    chk("s1_end_busy",  32'(a_if.busy), 32'd0);
    chk("s1_end_rdy",   32'(a_if.blk_ready), 32'd1);

    // same block, LSW first
    @(negedge clk);
    b_if.blk_valid = 1'b1; b_if.blk_data = BLK_X; b_if.wd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_if.blk_valid = 1'b0;
      #1;
      chk_word(1'b1, $sformatf("s4_w%0d", i), xw[3-i], i, (i == 3));
    end
    @(negedge clk);
    #1;
    chk("s4_end_valid", 32'(b_if.wd_valid), 32'd0);

    // back-to-back blocks A then B
    @(negedge clk);
    a_if.blk_valid = 1'b1; a_if.blk_data = BLK_A; a_if.wd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) a_if.blk_data = BLK_B;
      if (i == 4) a_if.blk_valid = 1'b0;
      #1;
      chk_word(1'b0, $sformatf("s2_w%0d", i), msw_word((i < 4) ? BLK_A : BLK_B, i % 4),
               i % 4, ((i % 4) == 3));
      chk($sformatf("s2_rdy%0d", i), 32'(a_if.blk_ready), 32'((i % 4) == 3));
    end
    @(negedge clk);
    #1;
    chk("s2_end_valid", 32'(a_if.wd_valid), 32'd0);

    // backpressure 1,0,0,1,0,1,1
    pat = 7'b1101001;
    @(negedge clk);
    a_if.blk_valid = 1'b1; a_if.blk_data = BLK_X; a_if.wd_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      a_if.blk_valid = 1'b0;
      a_if.wd_ready  = pat[k];
      #1;
      chk_word(1'b0, $sformatf("s3_k%0d", k), xw[cnt], cnt, (cnt == 3));
      chk($sformatf("s3_rdy%0d", k), 32'(a_if.blk_ready), 32'((cnt == 3) && pat[k]));
      if (pat[k]) cnt++;
    end
    @(negedge clk);
    a_if.wd_ready = 1'b1;
    #1;
    chk("s3_end_valid", 32'(a_if.wd_valid), 32'd0);

    // reset mid-block after word 1 has transferred
    @(negedge clk);
    a_if.blk_valid = 1'b1; a_if.blk_data = BLK_X;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_if.blk_valid = 1'b0;
      #1;
      chk_word(1'b0, $sformatf("s5_w%0d", i), xw[i], i, 1'b0);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 32'(a_if.wd_valid), 32'd0);
    chk("s5_rst_busy",  32'(a_if.busy), 32'd0);
    chk("s5_rst_idx",   32'(a_if.wd_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s5_rel_rdy",   32'(a_if.blk_ready), 32'd1);
    chk("s5_rel_valid", 32'(a_if.wd_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("s5_idle_valid", 32'(a_if.wd_valid), 32'd0);
    a_if.blk_valid = 1'b1; a_if.blk_data = BLK_C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_if.blk_valid = 1'b0;
      #1;
      chk_word(1'b0, $sformatf("s5_n%0d", i), msw_word(BLK_C, i), i, (i == 3));
    end
    @(negedge clk);
    #1;
    chk("s5_end_valid", 32'(a_if.wd_valid), 32'd0);

    // blk_valid during SEND with idx<3 must be ignored
    @(negedge clk);
    a_if.blk_valid = 1'b1; a_if.blk_data = BLK_X;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_if.blk_valid = (i < 3);
      a_if.blk_data  = BLK_D;
      #1;
      chk_word(1'b0, $sformatf("s6_w%0d", i), xw[i], i, (i == 3));
      chk($sformatf("s6_rdy%0d", i), 32'(a_if.blk_ready), 32'(i == 3));
    end
    @(negedge clk);
    #1;
    chk("s6_end_valid", 32'(a_if.wd_valid), 32'd0);
    chk("s6_end_busy",  32'(a_if.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
